irq_source: RTL and testbench
=============================

# irq_source

Interrupt request source for the interrupt pipeline CPU: it turns three raw external event inputs (board buttons or bench stimulus) into the CPU's `IRQ[2:0]` request lines. It also consumes the CPU's `IRW[2:0]` service-indication lines as the acknowledge side of that handshake. Each line has its own synchronizer, debouncer, pending-event counter and request FSM. The block sits between the board I/O and `cpu` at the top level.

## Interface
- `NIRQ`, 3: number of interrupt lines.
- `DB_CYCLES`, 16: consecutive stable cycles required before the debounced level changes; 0 means no filtering, the level follows the synchronizer through one register.
- `PW`, 2: width of the per-line pending counter, which saturates at 2^PW−1.
- `GAP_CYCLES`, 2: minimum number of cycles `IRQ[i]` is held low between two requests on the same line; values below 1 are treated as 1.

- `clk`, in, 1: system clock.
- `rst`, in, 1: asynchronous reset, active-low.
- `ev_in`, in, NIRQ: raw asynchronous event inputs; a rising edge is one event.
- `sw_trig`, in, NIRQ: synchronous single-cycle event pulses; bypass the synchronizer and debouncer.
- `IRW`, in, NIRQ: from the CPU; `IRW[i]` high means the CPU has taken or is servicing line i.
- `ovf_clr`, in, NIRQ: synchronous clear of the `ovf` flags.
- `IRQ`, out, NIRQ: request lines to the CPU.
- `pend`, out, NIRQ*PW: per-line pending count, line i at bits [i*PW +: PW].
- `ovf`, out, NIRQ: sticky flag per line; an event was dropped because the line's counter was saturated.

## Operation
- **Event path (per line):** `ev_in[i]` → 2-FF synchronizer → debouncer → registered filtered level `filt`.
  - The debouncer counts consecutive edges at which the synchronized value differs from `filt`.
  - When the count reaches `DB_CYCLES`, `filt` takes the new value; any agreement before that resets the count.
  - `ev = (filt & ~filt_d) | sw_trig[i]`.
- **Pending counter:**
  - `ev` increments `pend[i]`.
  - The REQ→SERV transition decrements `pend[i]`.
  - Increment and decrement in the same cycle: no change.
  - `ev` while `pend[i]` is at maximum and no decrement that cycle: the event is dropped, `ovf[i]` is set, `pend[i]` is unchanged.
  - `ovf_clr[i]` clears `ovf[i]`; if a set and a clear hit the same cycle, the set wins.
- **Request FSM (per line):**
  - IDLE: `IRQ[i]`=0. If `pend[i]`≠0, go to REQ.
  - REQ: `IRQ[i]`=1. If `IRW[i]`=1, go to SERV and decrement `pend[i]`.
  - SERV: `IRQ[i]`=0. If `IRW[i]`=0, go to GAP and load the gap counter.
  - GAP: `IRQ[i]`=0 for `GAP_CYCLES` cycles, then go to IDLE.
- `IRW[i]` high in IDLE or GAP is spurious and ignored; it has no state effect.
- Lines are fully independent. The block performs no priority arbitration; the CPU resolves priority.

## Timing
- All state is updated on the `clk` rising edge.
- `IRQ` is a registered output, decoded directly from the FSM state.
- **Reset** (`rst` low, asynchronous, any state including mid-handshake):
  - `IRQ`=0, `pend`=0, `ovf`=0; FSMs go to IDLE; synchronizers, `filt`, `filt_d` and all counters are cleared.
  - Events in flight are discarded.
- **Latency from `ev_in[i]`:** `ev_in[i]` is first sampled high at edge E, held stable, with the line in IDLE and `pend[i]`=0.
  - `filt` rises at edge E+2+DB_CYCLES.
  - `pend[i]` becomes 1 at E+3+DB_CYCLES.
  - `IRQ[i]` rises at E+4+DB_CYCLES.
- **Latency from `sw_trig[i]`:** a pulse sampled at edge T gives `pend[i]`=1 at T and `IRQ[i]`=1 at T+1.
- **Acknowledge:** `IRQ[i]` falls at the first edge at which `IRW[i]`=1 is sampled, and `pend[i]` decrements at that same edge.
- **Re-request:** after `IRW[i]` is sampled low, `IRQ[i]` stays low for at least GAP_CYCLES+1 edges. It then re-asserts one edge after IDLE is entered, if `pend[i]`≠0.
- **Glitch rejection:** a pulse on `ev_in[i]` shorter than DB_CYCLES synchronized cycles produces no event.

## Structure
- Shared package `irq_pkg`:
  - FSM state encoding IDLE/REQ/SERV/GAP (2 bits).
  - Default values of `DB_CYCLES`, `PW`, `GAP_CYCLES`.
- Sub-module `irq_line`: one line's synchronizer, debouncer, pending counter, FSM and `ovf` flag.
- `irq_source` instantiates `NIRQ` copies of `irq_line` with a generate loop and packs their outputs.

## Test plan
- **Reset:** assert `rst`=0 mid-REQ with `pend`=2 → `IRQ`=0, `pend`=0, `ovf`=0 immediately. After release, `sw_trig[0]` → `IRQ[0]` rises 1 edge later.
- **Debounce:** DB_CYCLES=4.
  - 3-cycle pulse on `ev_in[1]` → no `IRQ[1]`, `pend[1]` stays 0.
  - Stable high input → `IRQ[1]` rises at E+8.
- **Handshake:** `sw_trig[2]` at T; `IRW[2]` driven high 5 cycles later for 3 cycles → `IRQ[2]` falls at the IRW sample edge, `pend[2]` 1→0. No re-request afterwards.
- **Queueing:** three `sw_trig[0]` pulses before any ack → `pend[0]`=3. Ack each request → exactly three `IRQ[0]` assertions, each separated by ≥ GAP_CYCLES+1 low cycles.
- **Overflow and simultaneity:**
  - PW=2, five triggers with no ack → `pend[0]`=3, `ovf[0]`=1.
  - Trigger in the same cycle as an ack → `pend` unchanged.
  - `ovf_clr` together with a dropped event → `ovf` stays 1.
- **Spurious IRW:** `IRW[1]`=1 while IDLE → no state change. All three lines triggered in the same cycle → all `IRQ` bits rise together.

Source files
------------

// File: rtl/irq_pkg.sv
// rtl/irq_pkg.sv - shared types, defaults and helpers for the interrupt request source
// Purpose: request FSM state encoding, default parameter values, counter width helper.
// Ports: none (package).
package irq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_SERV = 2'd2,
        ST_GAP  = 2'd3
    } irq_state_t;

    localparam int DEF_DB_CYCLES  = 16;
    localparam int DEF_PW         = 2;
    localparam int DEF_GAP_CYCLES = 2;

    // Bits needed to hold values 0..max_val, never less than one.
    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/irq_line.sv
// rtl/irq_line.sv - one interrupt line: synchronizer, debouncer, pending counter, request FSM
// Purpose: converts one raw event input (plus a software trigger) into a request line
//          with a level handshake against the CPU service indication.
// Ports:
//   i_clk      system clock
//   i_rst_n    asynchronous active-low reset
//   i_ev       raw asynchronous event input, rising edge = one event
//   i_sw_trig  synchronous single-cycle event pulse
//   i_irw      CPU service indication for this line
//   i_ovf_clr  synchronous clear of the overflow flag
//   o_irq      request line to the CPU
//   o_pend     pending event count
//   o_ovf      sticky overflow flag
module irq_line
    import irq_pkg::*;
#(
    parameter int DB_CYCLES  = DEF_DB_CYCLES,
    parameter int PW         = DEF_PW,
    parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_ev,
    input  logic          i_sw_trig,
    input  logic          i_irw,
    input  logic          i_ovf_clr,
    output logic          o_irq,
    output logic [PW-1:0] o_pend,
    output logic          o_ovf
);

    localparam int DBW     = cnt_w(DB_CYCLES);
    localparam int GAP_EFF = (GAP_CYCLES < 1) ? 1 : GAP_CYCLES;
    localparam int GW      = cnt_w(GAP_EFF - 1);

    localparam logic [DBW-1:0] DB_MAX    = DBW'(DB_CYCLES);
    localparam logic [GW-1:0]  GAP_LOAD  = GW'(GAP_EFF - 1);
    localparam logic [PW-1:0]  PEND_MAX  = {PW{1'b1}};
    localparam logic [PW-1:0]  PEND_ONE  = PW'(1);

    logic           r_sync1;
    logic           r_sync2;
    logic [DBW-1:0] r_db_cnt;
    logic           r_filt;
    logic           r_filt_d;
    logic [PW-1:0]  r_pend;
    logic           r_ovf;
    logic [GW-1:0]  r_gap_cnt;
    irq_state_t     r_state;

    irq_state_t     w_state_nx;
    logic           w_dec;
    logic           w_gap_load;
    logic           w_ev;
    logic           w_full;
    logic           w_drop;

    // Two-flop synchronizer for the asynchronous event input.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_ev;
            r_sync2 <= r_sync1;
        end
    end

    // Debouncer: the filtered level flips on the edge after DB_CYCLES consecutive
    // disagreeing samples have been counted. With DB_CYCLES = 0 the count is already
    // at its limit, so the level simply follows the synchronizer through one register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_db_cnt <= '0;
            r_filt   <= 1'b0;
            r_filt_d <= 1'b0;
        end else begin
            r_filt_d <= r_filt;
            if (r_sync2 != r_filt) begin
                if (r_db_cnt == DB_MAX) begin
                    r_filt   <= r_sync2;
                    r_db_cnt <= '0;
                end else begin
                    r_db_cnt <= r_db_cnt + DBW'(1);
                end
            end else begin
                r_db_cnt <= '0;
            end
        end
    end

    assign w_ev   = (r_filt & ~r_filt_d) | i_sw_trig;
    assign w_full = (r_pend == PEND_MAX);
    // An event is only lost when the counter is full and no request is being taken.
    assign w_drop = w_ev & ~w_dec & w_full;

    // Pending counter; simultaneous increment and decrement cancel.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pend <= '0;
        end else if (w_ev && !w_dec && !w_full) begin
            r_pend <= r_pend + PEND_ONE;
        end else if (w_dec && !w_ev) begin
            r_pend <= r_pend - PEND_ONE;
        end
    end

    // Sticky overflow flag; a new drop takes precedence over a clear.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (i_ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_dec      = 1'b0;
        w_gap_load = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_pend != '0) begin
                    w_state_nx = ST_REQ;
                end
            end
            ST_REQ: begin
                if (i_irw) begin
                    w_state_nx = ST_SERV;
                    w_dec      = 1'b1;
                end
            end
            ST_SERV: begin
                if (!i_irw) begin
                    w_state_nx = ST_GAP;
                    w_gap_load = 1'b1;
                end
            end
            ST_GAP: begin
                if (r_gap_cnt == '0) begin
                    w_state_nx = ST_IDLE;
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    // Gap counter holds GAP for exactly GAP_EFF cycles: loaded with GAP_EFF-1 on entry,
    // IDLE is taken once it reads zero.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_gap_cnt <= '0;
        end else if (w_gap_load) begin
            r_gap_cnt <= GAP_LOAD;
        end else if (r_state == ST_GAP && r_gap_cnt != '0) begin
            r_gap_cnt <= r_gap_cnt - GW'(1);
        end
    end

    assign o_irq  = (r_state == ST_REQ);
    assign o_pend = r_pend;
    assign o_ovf  = r_ovf;

endmodule

// File: rtl/irq_source.sv
// rtl/irq_source.sv - interrupt request source: NIRQ independent request lines for the CPU
// Purpose: instantiates one irq_line per interrupt and packs their outputs; no priority
//          arbitration is done here, the CPU resolves priority.
// Ports:
//   clk      system clock
//   rst      asynchronous active-low reset
//   ev_in    raw asynchronous event inputs
//   sw_trig  synchronous single-cycle event pulses
//   IRW      CPU service indication per line
//   ovf_clr  synchronous clear of the overflow flags
//   IRQ      request lines to the CPU
//   pend     pending counts, line i at [i*PW +: PW]
//   ovf      sticky overflow flags
module irq_source
    import irq_pkg::*;
#(
    parameter int NIRQ       = 3,
    parameter int DB_CYCLES  = DEF_DB_CYCLES,
    parameter int PW         = DEF_PW,
    parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NIRQ-1:0]    ev_in,
    input  logic [NIRQ-1:0]    sw_trig,
    input  logic [NIRQ-1:0]    IRW,
    input  logic [NIRQ-1:0]    ovf_clr,
    output logic [NIRQ-1:0]    IRQ,
    output logic [NIRQ*PW-1:0] pend,
    output logic [NIRQ-1:0]    ovf
);

    for (genvar g = 0; g < NIRQ; g++) begin : g_line
        irq_line #(
            .DB_CYCLES  (DB_CYCLES),
            .PW         (PW),
            .GAP_CYCLES (GAP_CYCLES)
        ) u_line (
            .i_clk     (clk),
            .i_rst_n   (rst),
            .i_ev      (ev_in[g]),
            .i_sw_trig (sw_trig[g]),
            .i_irw     (IRW[g]),
            .i_ovf_clr (ovf_clr[g]),
            .o_irq     (IRQ[g]),
            .o_pend    (pend[g*PW +: PW]),
            .o_ovf     (ovf[g])
        );
    end

endmodule

// File: tb/tb_irq_source.sv
// tb/tb_irq_source.sv - directed self-checking bench for irq_source
module tb_irq_source;

    localparam int NIRQ = 3;
    localparam int DB   = 4;
    localparam int PW   = 2;
    localparam int GAP  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NIRQ-1:0]   ev_in;
    logic [NIRQ-1:0]   sw_trig;
    logic [NIRQ-1:0]   IRW;
    logic [NIRQ-1:0]   ovf_clr;
    logic [NIRQ-1:0]   IRQ;
    logic [NIRQ*PW-1:0] pend;
    logic [NIRQ-1:0]   ovf;

    int n_vec = 0;
    int n_err = 0;
    int rises;
    int min_gap;

    irq_source #(
        .NIRQ       (NIRQ),
        .DB_CYCLES  (DB),
        .PW         (PW),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .ev_in   (ev_in),
        .sw_trig (sw_trig),
        .IRW     (IRW),
        .ovf_clr (ovf_clr),
        .IRQ     (IRQ),
        .pend    (pend),
        .ovf     (ovf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Acknowledges every request on line 0 for a fixed number of cycles, counting
    // rising edges of IRQ[0] and the shortest low run preceding a re-request.
    task automatic serve0(input int cycles, output int r, output int mg);
        logic p;
        logic cur;
        int   lr;
        p  = IRQ[0];
        r  = IRQ[0] ? 1 : 0;
        lr = 0;
        mg = 1000;
        for (int c = 0; c < cycles; c++) begin
            IRW[0] = IRQ[0];
            tick();
            cur = IRQ[0];
            if (cur && !p) begin
                r++;
                if (lr < mg) mg = lr;
            end
            lr = cur ? 0 : lr + 1;
            p  = cur;
        end
        IRW[0] = 1'b0;
    endtask

    int exp_p [5] = '{1, 2, 3, 3, 3};
    int exp_o [5] = '{0, 0, 0, 1, 1};

    initial begin
        rst = 1'b0; ev_in = '0; sw_trig = '0; IRW = '0; ovf_clr = '0;
        tick(); tick();
        chk("rst_irq", 8'(IRQ), 8'h00);
        chk("rst_pend", 8'(pend), 8'h00);
        chk("rst_ovf", 8'(ovf), 8'h00);
        rst = 1'b1;
        tick();
        chk("post_rst_irq", 8'(IRQ), 8'h00);

        // Software trigger latency, then reset mid-REQ with pend=2
        sw_trig = 3'b001; tick(); sw_trig = '0;
        chk("sw_pend_T", 8'(pend), 8'h01);
        chk("sw_irq_T", 8'(IRQ), 8'h00);
        tick();
        chk("sw_irq_T1", 8'(IRQ), 8'h01);
        sw_trig = 3'b001; tick(); sw_trig = '0;
        chk("req_pend2", 8'(pend), 8'h02);
        chk("req_irq", 8'(IRQ), 8'h01);
        rst = 1'b0; #1;
        chk("async_rst_irq", 8'(IRQ), 8'h00);
        chk("async_rst_pend", 8'(pend), 8'h00);
        chk("async_rst_ovf", 8'(ovf), 8'h00);
        tick(); rst = 1'b1; tick();
        chk("rel_irq", 8'(IRQ), 8'h00);
        sw_trig = 3'b001; tick(); sw_trig = '0;
        chk("rel_sw_pend", 8'(pend), 8'h01);
        chk("rel_sw_irq_T", 8'(IRQ), 8'h00);
        tick();
        chk("rel_sw_irq_T1", 8'(IRQ), 8'h01);
        IRW = 3'b001; tick(); IRW = '0;
        chk("rel_ack_irq", 8'(IRQ), 8'h00);
        chk("rel_ack_pend", 8'(pend), 8'h00);
        repeat (5) tick();

        // Glitch of 3 synchronized cycles on line 1 must be rejected
        ev_in = 3'b010; repeat (3) tick(); ev_in = '0;
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("glitch_irq", 8'(IRQ), 8'h00);
        end
        chk("glitch_pend", 8'(pend), 8'h00);

        // Stable input: pend at E+7, IRQ at E+8
        ev_in = 3'b010; repeat (7) tick();
        chk("db_pend_E6", 8'(pend), 8'h00);
        chk("db_irq_E6", 8'(IRQ), 8'h00);
        tick();
        chk("db_pend_E7", 8'(pend), 8'h04);
        chk("db_irq_E7", 8'(IRQ), 8'h00);
        tick();
        chk("db_irq_E8", 8'(IRQ), 8'h02);
        IRW = 3'b010; tick(); IRW = '0;
        chk("db_ack_irq", 8'(IRQ), 8'h00);
        chk("db_ack_pend", 8'(pend), 8'h00);
        ev_in = '0; repeat (12) tick();
        chk("db_fall_irq", 8'(IRQ), 8'h00);
        chk("db_fall_pend", 8'(pend), 8'h00);

        // Handshake on line 2, IRW high 5 cycles after T for 3 cycles
        sw_trig = 3'b100; tick(); sw_trig = '0;
        chk("hs_pend", 8'(pend), 8'h10);
        tick();
        chk("hs_irq", 8'(IRQ), 8'h04);
        repeat (4) tick();
        chk("hs_irq_hold", 8'(IRQ), 8'h04);
        IRW = 3'b100; tick();
        chk("hs_ack_irq", 8'(IRQ), 8'h00);
        chk("hs_ack_pend", 8'(pend), 8'h00);
        tick(); tick();
        chk("hs_serv_irq", 8'(IRQ), 8'h00);
        IRW = '0;
        for (int c = 0; c < 8; c++) begin
            tick();
            chk("hs_no_rereq", 8'(IRQ), 8'h00);
        end

        // Queueing: three triggers, three spaced requests
        sw_trig = 3'b001; tick(); tick(); tick(); sw_trig = '0;
        chk("q_pend3", 8'(pend), 8'h03);
        chk("q_irq", 8'(IRQ), 8'h01);
        serve0(40, rises, min_gap);
        chk("q_rises", 8'(rises), 8'd3);
        chk("q_min_gap", 8'(min_gap), 8'd4);
        chk("q_pend_end", 8'(pend), 8'h00);

        // Overflow: five triggers with no ack
        for (int i = 0; i < 5; i++) begin
            sw_trig = 3'b001; tick();
            chk("ovf_pend", 8'(pend), 8'(exp_p[i]));
            chk("ovf_flag", 8'(ovf), 8'(exp_o[i]));
        end
        sw_trig = '0;
        ovf_clr = 3'b001; sw_trig = 3'b001; tick(); ovf_clr = '0; sw_trig = '0;
        chk("ovf_set_wins", 8'(ovf), 8'h01);
        chk("ovf_set_pend", 8'(pend), 8'h03);
        ovf_clr = 3'b001; tick(); ovf_clr = '0;
        chk("ovf_clr", 8'(ovf), 8'h00);
        IRW = 3'b001; sw_trig = 3'b001; tick(); IRW = '0; sw_trig = '0;
        chk("simul_pend", 8'(pend), 8'h03);
        chk("simul_ovf", 8'(ovf), 8'h00);
        chk("simul_irq", 8'(IRQ), 8'h00);
        serve0(40, rises, min_gap);
        chk("drain_rises", 8'(rises), 8'd3);
        chk("drain_pend", 8'(pend), 8'h00);

        // Spurious IRW while IDLE, then all lines triggered together
        IRW = 3'b010;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("spur_irq", 8'(IRQ), 8'h00);
            chk("spur_pend", 8'(pend), 8'h00);
        end
        IRW = '0;
        sw_trig = 3'b111; tick(); sw_trig = '0;
        chk("all_pend", 8'(pend), 8'h15);
        chk("all_irq_T", 8'(IRQ), 8'h00);
        tick();
        chk("all_irq_T1", 8'(IRQ), 8'h07);
        IRW = 3'b111; tick(); IRW = '0;
        chk("all_ack_irq", 8'(IRQ), 8'h00);
        chk("all_ack_pend", 8'(pend), 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
